// File: rtl/addsub_div_pkg.sv
// Shared types and constants for the add/sub-driven restoring divider.
package addsub_div_pkg;
   localparam int          DIV_ITERS = 32;
   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_NEG_A = 3'd1,
      S_NEG_B = 3'd2,
      S_ITER  = 3'd3,
      S_FIX_Q = 3'd4,
      S_FIX_R = 3'd5,
      S_DONE  = 3'd6
   } div_state_t;
endpackage

// File: rtl/addsub_div_step.sv
// One restoring-division step: builds the shifted partial remainder and
// picks the subtracted or unchanged value from the external unit's answer.
module addsub_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_au_result,
   input  logic             i_au_sign,
   output logic [WIDTH-1:0] o_rs,
   output logic [WIDTH-1:0] o_rem_nxt,
   output logic [WIDTH-1:0] o_q_nxt
);
   logic w_take;

   // rem[31] set means the shifted value lost its 33rd bit, so it certainly
   // exceeds the divisor and the subtraction must be taken regardless of borrow.
   always_comb begin
      o_rs      = {i_rem[WIDTH-2:0], i_q[WIDTH-1]};
      w_take    = i_rem[WIDTH-1] | ~i_au_sign;
      o_rem_nxt = w_take ? i_au_result : o_rs;
      o_q_nxt   = {i_q[WIDTH-2:0], w_take};
   end
endmodule

// File: rtl/addsub_div_sequencer.sv
// Multi-cycle 32-bit DIV/REM controller driving a shared external add/sub unit.
// Optional signed support is enabled by defining ADDSUB_DIV_SIGNED_EN.
module addsub_div_sequencer
   import addsub_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quot,
   output logic [WIDTH-1:0] out_rem,
   output logic [WIDTH-1:0] au_x,
   output logic [WIDTH-1:0] au_y,
   output logic             au_ctrl,
   input  logic [WIDTH-1:0] au_result,
   input  logic             au_sign
);
   localparam int CNT_W = $clog2(DIV_ITERS);

   div_state_t       r_state, w_state_nxt;
   logic [WIDTH-1:0] r_q, r_rem, r_div;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cool;
   logic             w_accept;
   logic [WIDTH-1:0] w_rs, w_rem_nxt, w_q_nxt;
`ifdef ADDSUB_DIV_SIGNED_EN
   logic             r_sgn, r_sa, r_sb;
`else
   logic             w_unused_signed;
   assign w_unused_signed = in_signed;
`endif

   // r_cool holds off in_ready for the cycle right after a result transfer.
   assign in_ready  = (r_state == S_IDLE) && !r_cool;
   assign w_accept  = in_valid && in_ready;
   assign out_valid = (r_state == S_DONE);
   assign out_quot  = r_q;
   assign out_rem   = r_rem;
   assign au_ctrl   = 1'b1;

   addsub_div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem       (r_rem),
      .i_q         (r_q),
      .i_au_result (au_result),
      .i_au_sign   (au_sign),
      .o_rs        (w_rs),
      .o_rem_nxt   (w_rem_nxt),
      .o_q_nxt     (w_q_nxt)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state selection and add/sub operand steering.
   always_comb begin
      w_state_nxt = r_state;
      au_x        = '0;
      au_y        = '0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (in_b == '0) w_state_nxt = S_DONE;
`ifdef ADDSUB_DIV_SIGNED_EN
               else if (in_signed) w_state_nxt = S_NEG_A;
`endif
               else w_state_nxt = S_ITER;
            end
         end
         S_ITER: begin
            au_x = w_rs;
            au_y = r_div;
            if (r_cnt == CNT_W'(DIV_ITERS - 1)) begin
`ifdef ADDSUB_DIV_SIGNED_EN
               w_state_nxt = r_sgn ? S_FIX_Q : S_DONE;
`else
               w_state_nxt = S_DONE;
`endif
            end
         end
`ifdef ADDSUB_DIV_SIGNED_EN
         S_NEG_A: begin au_y = r_q;   w_state_nxt = S_NEG_B; end
         S_NEG_B: begin au_y = r_div; w_state_nxt = S_ITER;  end
         S_FIX_Q: begin au_y = r_q;   w_state_nxt = S_FIX_R; end
         S_FIX_R: begin au_y = r_rem; w_state_nxt = S_DONE;  end
`endif
         S_DONE: if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand latch, iteration update and sign handling of the datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q    <= '0;
         r_rem  <= '0;
         r_div  <= '0;
         r_cnt  <= '0;
         r_cool <= 1'b0;
`ifdef ADDSUB_DIV_SIGNED_EN
         r_sgn  <= 1'b0;
         r_sa   <= 1'b0;
         r_sb   <= 1'b0;
`endif
      end else begin
         r_cool <= (r_state == S_DONE) && out_ready;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_div <= in_b;
                  r_cnt <= '0;
                  if (in_b == '0) begin
                     r_q   <= DIV0_QUOT;
                     r_rem <= in_a;
                  end else begin
                     r_q   <= in_a;
                     r_rem <= '0;
                  end
`ifdef ADDSUB_DIV_SIGNED_EN
                  r_sgn <= in_signed;
                  r_sa  <= in_signed & in_a[WIDTH-1];
                  r_sb  <= in_signed & in_b[WIDTH-1];
`endif
               end
            end
            S_ITER: begin
               r_q   <= w_q_nxt;
               r_rem <= w_rem_nxt;
               r_cnt <= r_cnt + CNT_W'(1);
            end
`ifdef ADDSUB_DIV_SIGNED_EN
            S_NEG_A: if (r_sa)        r_q   <= au_result;
            S_NEG_B: if (r_sb)        r_div <= au_result;
            S_FIX_Q: if (r_sa ^ r_sb) r_q   <= au_result;
            S_FIX_R: if (r_sa)        r_rem <= au_result;
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_addsub_div_sequencer.sv
// Self-checking bench for addsub_div_sequencer with a behavioural add/sub unit.
module tb_addsub_div_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] in_a = '0, in_b = '0;
   logic        in_signed = 1'b0;
   logic        out_valid, out_ready = 1'b1;
   logic [31:0] out_quot, out_rem, au_x, au_y, au_result;
   logic        au_ctrl, au_sign;

   typedef struct { logic [31:0] q; logic [31:0] r; } exp_t;
   exp_t exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // External add/sub unit as the parent would provide it.
   assign au_result = au_x - au_y;
   assign au_sign   = (au_x < au_y);

   addsub_div_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_quot(out_quot), .out_rem(out_rem),
      .au_x(au_x), .au_y(au_y), .au_ctrl(au_ctrl),
      .au_result(au_result), .au_sign(au_sign)
   );

   task automatic tick();
      @(posedge clk); #1;
   endtask

   function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
      exp_t e;
      logic [31:0] ua, ub, uq, ur;
      logic sa, sb;
      if (b == 32'd0) begin
         e.q = 32'hFFFF_FFFF;
         e.r = a;
         return e;
      end
`ifdef ADDSUB_DIV_SIGNED_EN
      sa = s & a[31];
      sb = s & b[31];
`else
      sa = s & 1'b0;
      sb = 1'b0;
`endif
      ua = sa ? -a : a;
      ub = sb ? -b : b;
      uq = ua / ub;
      ur = ua % ub;
      e.q = (sa ^ sb) ? -uq : uq;
      e.r = sa ? -ur : ur;
      return e;
   endfunction

   // Drives one request, waits for the result and transfers it (out_ready=1).
   // lat counts cycles from the accept cycle to the first out_valid cycle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output logic [31:0] q, output logic [31:0] r,
                         output logic rdy_seen);
      int g = 0;
      in_a = a; in_b = b; in_signed = s; in_valid = 1'b1; out_ready = 1'b1;
      while (!in_ready && g < 200) begin tick(); g++; end
      tick();
      in_valid = 1'b0;
      lat = 1;
      rdy_seen = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) rdy_seen = 1'b1;
         tick();
         lat++;
      end
      if (in_ready) rdy_seen = 1'b1;
      q = out_quot;
      r = out_rem;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_vec++; if (out_quot !== 32'd0) begin n_err++; $display("FAIL reset_quot: got %h want 0", out_quot); end
      n_vec++; if (out_rem !== 32'd0) begin n_err++; $display("FAIL reset_rem: got %h want 0", out_rem); end
      n_vec++; if (au_x !== 32'd0 || au_y !== 32'd0) begin n_err++; $display("FAIL reset_au: got x=%h y=%h want 0", au_x, au_y); end
      n_vec++; if (au_ctrl !== 1'b1) begin n_err++; $display("FAIL reset_au_ctrl: got %b want 1", au_ctrl); end
      rst = 1'b0;
      tick();
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_unsigned_basic();
      int lat; logic [31:0] q, r; logic rs; exp_t e;
      exp_q.push_back(ref_div(32'd100, 32'd7, 1'b0));
      run_op(32'd100, 32'd7, 1'b0, lat, q, r, rs);
      e = exp_q.pop_front();
      n_vec++; if (q !== 32'd14 || q !== e.q) begin n_err++; $display("FAIL u100_7_quot: got %0d want 14", q); end
      n_vec++; if (r !== 32'd2 || r !== e.r) begin n_err++; $display("FAIL u100_7_rem: got %0d want 2", r); end
      n_vec++; if (lat !== 33) begin n_err++; $display("FAIL u_latency: got %0d want 33", lat); end
      n_vec++; if (rs !== 1'b0) begin n_err++; $display("FAIL u_in_ready_busy: got %b want 0", rs); end
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL in_ready_T34: got %b want 0", in_ready); end
      tick();
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL in_ready_T35: got %b want 1", in_ready); end
      n_vec++; if (au_x !== 32'd0 || au_y !== 32'd0) begin n_err++; $display("FAIL idle_au: got x=%h y=%h want 0", au_x, au_y); end
   endtask

   task automatic test_rem31();
      int lat; logic [31:0] q, r; logic rs; exp_t e;
      exp_q.push_back(ref_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0));
      run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, lat, q, r, rs);
      e = exp_q.pop_front();
      n_vec++; if (q !== 32'd1 || q !== e.q) begin n_err++; $display("FAIL rem31_quot: got %h want 1", q); end
      n_vec++; if (r !== 32'h7FFF_FFFE || r !== e.r) begin n_err++; $display("FAIL rem31_rem: got %h want 7ffffffe", r); end
      tick();
   endtask

   task automatic test_div0();
      int lat; logic [31:0] q, r; logic rs; exp_t e;
      exp_q.push_back(ref_div(32'h1234, 32'd0, 1'b1));
      run_op(32'h1234, 32'd0, 1'b1, lat, q, r, rs);
      e = exp_q.pop_front();
      n_vec++; if (lat !== 1) begin n_err++; $display("FAIL div0_latency: got %0d want 1", lat); end
      n_vec++; if (q !== 32'hFFFF_FFFF || q !== e.q) begin n_err++; $display("FAIL div0_quot: got %h want ffffffff", q); end
      n_vec++; if (r !== 32'h1234 || r !== e.r) begin n_err++; $display("FAIL div0_rem: got %h want 1234", r); end
      tick();
   endtask

   task automatic test_signed();
      int lat; logic [31:0] q, r; logic rs; exp_t e;
`ifdef ADDSUB_DIV_SIGNED_EN
      exp_q.push_back(ref_div(-32'sd7, 32'd2, 1'b1));
      run_op(-32'sd7, 32'd2, 1'b1, lat, q, r, rs);
      e = exp_q.pop_front();
      n_vec++; if (q !== -32'sd3 || q !== e.q) begin n_err++; $display("FAIL s_m7_2_quot: got %h want fffffffd", q); end
      n_vec++; if (r !== -32'sd1 || r !== e.r) begin n_err++; $display("FAIL s_m7_2_rem: got %h want ffffffff", r); end
      n_vec++; if (lat !== 37) begin n_err++; $display("FAIL s_latency: got %0d want 37", lat); end
      n_vec++; if (rs !== 1'b0) begin n_err++; $display("FAIL s_in_ready_busy: got %b want 0", rs); end
      tick();
      exp_q.push_back(ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1));
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, q, r, rs);
      e = exp_q.pop_front();
      n_vec++; if (q !== 32'h8000_0000 || q !== e.q) begin n_err++; $display("FAIL s_min_m1_quot: got %h want 80000000", q); end
      n_vec++; if (r !== 32'd0 || r !== e.r) begin n_err++; $display("FAIL s_min_m1_rem: got %h want 0", r); end
`else
      // Without signed support the flag is ignored: unsigned result, unsigned latency.
      exp_q.push_back(ref_div(-32'sd7, 32'd2, 1'b0));
      run_op(-32'sd7, 32'd2, 1'b1, lat, q, r, rs);
      e = exp_q.pop_front();
      n_vec++; if (q !== 32'h7FFF_FFFC || q !== e.q) begin n_err++; $display("FAIL nosign_quot: got %h want 7ffffffc", q); end
      n_vec++; if (r !== 32'd1 || r !== e.r) begin n_err++; $display("FAIL nosign_rem: got %h want 1", r); end
      n_vec++; if (lat !== 33) begin n_err++; $display("FAIL nosign_latency: got %0d want 33", lat); end
`endif
      tick();
   endtask

   task automatic test_backpressure();
      int g = 0; logic [31:0] q0, r0; exp_t e;
      exp_q.push_back(ref_div(32'd1000, 32'd33, 1'b0));
      in_a = 32'd1000; in_b = 32'd33; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      while (!in_ready && g < 200) begin tick(); g++; end
      tick();
      in_valid = 1'b0;
      g = 0;
      while (!out_valid && g < 200) begin tick(); g++; end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_timeout: got out_valid=%b want 1", out_valid); end
      q0 = out_quot; r0 = out_rem;
      e = exp_q.pop_front();
      n_vec++; if (q0 !== e.q || r0 !== e.r) begin n_err++; $display("FAIL bp_result: got %0d/%0d want %0d/%0d", q0, r0, e.q, e.r); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++;
         if (out_valid !== 1'b1 || out_quot !== q0 || out_rem !== r0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold%0d: got v=%b q=%h r=%h rdy=%b want v=1 q=%h r=%h rdy=0",
                     i, out_valid, out_quot, out_rem, in_ready, q0, r0);
         end
      end
      out_ready = 1'b1;
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", out_valid); end
      tick();
   endtask

   task automatic test_mid_reset();
      int g = 0;
      exp_q.push_back(ref_div(32'hDEAD_BEEF, 32'd3, 1'b0));
      in_a = 32'hDEAD_BEEF; in_b = 32'd3; in_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      while (!in_ready && g < 200) begin tick(); g++; end
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      void'(exp_q.pop_front());
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_out_valid: got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mrst_in_ready: got %b want 1", in_ready); end
      n_vec++; if (out_quot !== 32'd0 || out_rem !== 32'd0) begin n_err++; $display("FAIL mrst_outs: got q=%h r=%h want 0", out_quot, out_rem); end
      n_vec++; if (au_x !== 32'd0 || au_y !== 32'd0) begin n_err++; $display("FAIL mrst_au: got x=%h y=%h want 0", au_x, au_y); end
      // No stray result may appear afterwards.
      repeat (40) tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_ghost: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      localparam int NOPS = 400;
      int n_acc = 0, cyc = 0, prev_t = -1;
      logic prev_div0 = 1'b0;
      logic acc, outx;
      logic [31:0] oq, orr;
      exp_t e;
      in_signed = 1'b0; out_ready = 1'b1;
      in_a = $urandom; in_b = $urandom;
      in_valid = 1'b1;
      while ((n_acc < NOPS || exp_q.size() != 0) && cyc < 30000) begin
         acc  = in_valid && in_ready;
         outx = out_valid && out_ready;
         oq = out_quot; orr = out_rem;
         if (acc) exp_q.push_back(ref_div(in_a, in_b, 1'b0));
         tick();
         cyc++;
         if (outx) begin
            e = exp_q.pop_front();
            n_vec++;
            if (oq !== e.q || orr !== e.r) begin
               n_err++;
               $display("FAIL rnd_result: got q=%h r=%h want q=%h r=%h", oq, orr, e.q, e.r);
            end
         end
         if (acc) begin
            if (prev_t >= 0) begin
               n_vec++;
               if (cyc - prev_t !== (prev_div0 ? 3 : 35)) begin
                  n_err++;
                  $display("FAIL rnd_spacing: got %0d want %0d", cyc - prev_t, prev_div0 ? 3 : 35);
               end
            end
            prev_t = cyc;
            prev_div0 = (in_b == 32'd0);
            n_acc++;
            if (n_acc >= NOPS) in_valid = 1'b0;
            in_a = $urandom;
            case ($urandom_range(0, 9))
               0:       in_b = 32'd0;
               1:       in_b = 32'h8000_0000 | $urandom;
               2:       in_b = $urandom_range(1, 16);
               3:       begin in_b = $urandom; in_a = in_b >> 1; end
               default: in_b = $urandom;
            endcase
         end
      end
      in_valid = 1'b0;
      n_vec++;
      if (n_acc != NOPS || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL rnd_complete: got %0d accepts %0d pending want %0d accepts 0 pending",
                  n_acc, exp_q.size(), NOPS);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_rem31();
      test_div0();
      test_signed();
      test_backpressure();
      test_mid_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
